// File: rtl/frame_receiver_with_flow_control.sv
// Receives 10-bit start/stop framed words, strips the framing bits and assembles
// fixed-size frames. Handles pause words and counts malformed words.
module frame_receiver_with_flow_control #(
   parameter int FRAME_BYTES = 16,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     word_valid,
   input  logic [9:0]               word_in,
   output logic [7:0]               byte_out,
   output logic [3:0]               byte_index,
   output logic                     byte_valid,
   output logic [8*FRAME_BYTES-1:0] frame_data_out,
   output logic                     frame_valid,
   output logic                     frame_abort,
   output logic                     pause_detected,
   output logic                     pause_active,
   output logic                     framing_error,
   output logic [ERR_CNT_W-1:0]     error_count,
   output logic                     rx_active
);

   typedef enum logic [1:0] {
      IDLE,
      RECEIVE,
      PAUSED
   } state_t;

   localparam logic [3:0]           LAST_IDX = 4'(FRAME_BYTES - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

   state_t                   state;
   state_t                   state_next;
   logic [3:0]               cnt;
   logic [7:0]               buffer [16];
   logic                     is_pause;
   logic                     is_data;
   logic                     is_error;
   logic                     last_byte;
   logic [7:0]               data_byte;
   logic [8*FRAME_BYTES-1:0] frame_next;

   assign data_byte = word_in[8:1];
   assign is_pause  = word_valid && (word_in == 10'h000);
   assign is_data   = word_valid && !word_in[0] && word_in[9];
   assign is_error  = word_valid && !is_pause && !is_data;
   assign last_byte = (cnt == LAST_IDX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (is_pause) begin
         state_next = PAUSED;
      end else if (is_error) begin
         state_next = IDLE;
      end else if (is_data) begin
         state_next = last_byte ? IDLE : RECEIVE;
      end
   end

   // The completed frame must include the byte arriving this cycle, which is not yet in the buffer.
   always_comb begin
      frame_next = '0;
      for (int k = 0; k < FRAME_BYTES; k++) begin
         frame_next[8*k +: 8] = (4'(k) == cnt) ? data_byte : buffer[k];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt            <= '0;
         byte_out       <= '0;
         byte_index     <= '0;
         byte_valid     <= 1'b0;
         frame_data_out <= '0;
         frame_valid    <= 1'b0;
         frame_abort    <= 1'b0;
         pause_detected <= 1'b0;
         framing_error  <= 1'b0;
         error_count    <= '0;
         for (int k = 0; k < 16; k++) begin
            buffer[k] <= '0;
         end
      end else begin
         byte_valid     <= 1'b0;
         frame_valid    <= 1'b0;
         frame_abort    <= 1'b0;
         pause_detected <= 1'b0;
         framing_error  <= 1'b0;
         if (is_data) begin
            buffer[cnt] <= data_byte;
            byte_out    <= data_byte;
            byte_index  <= cnt;
            byte_valid  <= 1'b1;
            if (last_byte) begin
               frame_data_out <= frame_next;
               frame_valid    <= 1'b1;
               cnt            <= '0;
            end else begin
               cnt <= cnt + 4'd1;
            end
         end else if (is_pause || is_error) begin
            if (cnt != 4'd0) begin
               frame_abort <= 1'b1;
               cnt         <= '0;
            end
            pause_detected <= is_pause;
            framing_error  <= is_error;
            if (is_error && (error_count != '1)) begin
               error_count <= error_count + ERR_ONE;
            end
         end
      end
   end

   assign pause_active = (state == PAUSED);
   assign rx_active    = (state == RECEIVE);

endmodule
